// File: rtl/gen_timer_pkg.sv
// Shared constants and index-width helper for the generic timer bank and its bench.
package gen_timer_pkg;

  localparam int CH_MAX    = 16;
  localparam int WIDTH_MAX = 32;

  // Channel index width; a single channel still gets one index bit.
  function automatic int chw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gen_timer_ch.sv
// One down-counting timer channel: expiry sets pending one cycle after count==1 is ticked.
// No backpressure here; clr drops pending, and a further expiry while pending is not cleared marks overrun.
module gen_timer_ch #(
  parameter int WIDTH    = 8,
  parameter int ONE_SHOT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             clr,
  output logic             pending,
  output logic             overrun
);

  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload_val;
  logic             tick;
  logic             expire;

  assign tick   = en && (count != '0) && !load;
  assign expire = tick && (count == WIDTH'(1));

  generate
    if (ONE_SHOT != 0) begin : g_one_shot
      assign reload_val = '0;
    end else begin : g_reload
      assign reload_val = period;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      period  <= '0;
      count   <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        period <= load_val;
        count  <= load_val;
      end else if (tick) begin
        count <= expire ? reload_val : count - WIDTH'(1);
      end
      // A fresh expiry wins over a same-cycle clear.
      pending <= expire | (pending & ~clr);
      if (load) begin
        overrun <= 1'b0;
      end else if (expire && pending && !clr) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/gen_timer_bank.sv
// Bank of NUM_CH timers draining expiries through a round-robin valid/ready event port.
// evt_valid/evt_ch are combinational from registered pending/ptr; a held event waits for evt_ready.
module gen_timer_bank
  import gen_timer_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int WIDTH    = 8,
  parameter  int ONE_SHOT = 0,
  localparam int CHW      = chw(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [CHW-1:0]    load_ch,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [NUM_CH-1:0] en,
  output logic              evt_valid,
  output logic [CHW-1:0]    evt_ch,
  input  logic              evt_ready,
  output logic [NUM_CH-1:0] overrun
);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] clr;
  logic [CHW-1:0]    ptr;
  logic [CHW-1:0]    cand;
  logic              found;
  logic              accept;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign clr[i] = accept && (evt_ch == CHW'(i));
      gen_timer_ch #(
        .WIDTH    (WIDTH),
        .ONE_SHOT (ONE_SHOT)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .load     (load_valid && (load_ch == CHW'(i))),
        .load_val (load_val),
        .en       (en[i]),
        .clr      (clr[i]),
        .pending  (pending[i]),
        .overrun  (overrun[i])
      );
    end
  endgenerate

  assign evt_valid = |pending;
  assign accept    = evt_valid && evt_ready;

  // First pending channel at or above ptr, wrapping past the top.
  always_comb begin
    evt_ch = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CHW'((int'(ptr) + k) % NUM_CH);
      if (!found && pending[cand]) begin
        found  = 1'b1;
        evt_ch = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (evt_ch == CHW'(NUM_CH - 1)) ? '0 : evt_ch + CHW'(1);
    end
  end

endmodule
